// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, half-period type and 100 MHz default half-periods for the clock divider
package clkdiv_pkg;
  localparam int CNT_W_DEF = 27;
  typedef logic [CNT_W_DEF-1:0] half_t;
  localparam half_t HALF_10MHZ = 27'd5;
  localparam half_t HALF_1MHZ = 27'd50;
  localparam half_t HALF_1KHZ = 27'd50_000;
  localparam half_t HALF_1HZ = 27'd50_000_000;
  localparam logic [4*CNT_W_DEF-1:0] DEFAULT_HALF_100M = {HALF_1HZ, HALF_1KHZ, HALF_1MHZ, HALF_10MHZ};
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/div_channel.sv
// div_channel: one divider channel with shadowed half-period applied only at wrap
module div_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = '0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] cnt, active, shadow;
  logic [CNT_W-1:0] cnt_n, active_n, shadow_n;
  logic             clk_n, tick_n, wrap;
  always_comb begin
    shadow_n = wr ? cfg_half : shadow;
    wrap = (active != '0) && (cnt == active - 1'b1);
    cnt_n = cnt + 1'b1;
    active_n = active;
    clk_n = clk_out;
    tick_n = 1'b0;
    if (restart) begin
      cnt_n = '0;
      clk_n = 1'b0;
      active_n = shadow_n;
    end else if (active == '0) begin
      cnt_n = '0;
      clk_n = 1'b0;
      active_n = shadow;
    end else if (wrap) begin
      cnt_n = '0;
      active_n = shadow_n;
      clk_n = (shadow_n != '0) && !clk_out;
      tick_n = clk_n;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt <= '0;
      active <= DEFAULT_HALF;
      shadow <= DEFAULT_HALF;
      clk_out <= 1'b0;
      tick <= 1'b0;
      pending <= 1'b0;
    end else begin
      cnt <= cnt_n;
      active <= active_n;
      shadow <= shadow_n;
      clk_out <= clk_n;
      tick <= tick_n;
      pending <= shadow_n != active_n;
    end
  end
endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: N-channel programmable clock divider, address decode around per-channel dividers
module multi_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [N_CH*CNT_W-1:0] DEFAULT_HALF = DEFAULT_HALF_100M
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    cfg_we,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         pending
);
  localparam int CH_W = ch_w(N_CH);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    div_channel #(
      .CNT_W(CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_in(clk_in),
      .reset(reset),
      .restart(restart),
      .wr(cfg_we && (N_CH == 1 || cfg_ch == CH_W'(i))),
      .cfg_half(cfg_half),
      .clk_out(clk_out[i]),
      .tick(tick[i]),
      .pending(pending[i])
    );
  end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: directed and random checks of the divider against a countdown reference model
module tb_multi_clk_divider;
  logic       clk_in = 1'b0;
  logic       reset = 1'b1, restart = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_half = '0;
  logic [3:0] clk_out4, tick4, pend4;
  logic [2:0] clk_out3, tick3, pend3;
  int checks = 0, errors = 0, cyc = 0;
  int def[4] = '{5, 3, 2, 1};
  int m_act[4], m_shd[4], m_rem[4];
  bit m_lvl[4], m_tick[4];

  always #5 clk_in = ~clk_in;

  multi_clk_divider #(.N_CH(4), .CNT_W(8), .DEFAULT_HALF({8'd1, 8'd2, 8'd3, 8'd5})) u_dut (
    .clk_in(clk_in), .reset(reset), .restart(restart), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .clk_out(clk_out4), .tick(tick4), .pending(pend4));

  multi_clk_divider #(.N_CH(3), .CNT_W(8), .DEFAULT_HALF({8'd2, 8'd3, 8'd5})) u_dut3 (
    .clk_in(clk_in), .reset(reset), .restart(restart), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .clk_out(clk_out3), .tick(tick3), .pending(pend3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit rst_p, input bit we, input int ch, input int half);
    logic [3:0] e_clk, e_tick, e_pend;
    int sh_new;
    reset = rs; restart = rst_p; cfg_we = we; cfg_ch = ch[1:0]; cfg_half = half[7:0];
    for (int i = 0; i < 4; i++) begin
      sh_new = (we && ch == i) ? half : m_shd[i];
      m_tick[i] = 0;
      if (rs) begin
        m_act[i] = def[i]; m_shd[i] = def[i]; m_rem[i] = def[i]; m_lvl[i] = 0;
      end else if (rst_p) begin
        m_act[i] = sh_new; m_shd[i] = sh_new; m_rem[i] = sh_new; m_lvl[i] = 0;
      end else if (m_act[i] == 0) begin
        m_act[i] = m_shd[i]; m_shd[i] = sh_new; m_rem[i] = m_act[i]; m_lvl[i] = 0;
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_act[i] = sh_new;
          m_lvl[i] = (sh_new != 0) && !m_lvl[i];
          m_tick[i] = m_lvl[i];
          m_rem[i] = sh_new;
        end
        m_shd[i] = sh_new;
      end
    end
    for (int i = 0; i < 4; i++) begin
      e_clk[i] = m_lvl[i]; e_tick[i] = m_tick[i]; e_pend[i] = m_shd[i] != m_act[i];
    end
    @(posedge clk_in);
    #1;
    cyc++;
    chk("clk_out", 32'(clk_out4), 32'(e_clk));
    chk("tick", 32'(tick4), 32'(e_tick));
    chk("pending", 32'(pend4), 32'(e_pend));
    chk("clk_out n3", 32'(clk_out3), 32'(e_clk[2:0]));
    chk("tick n3", 32'(tick3), 32'(e_tick[2:0]));
    chk("pending n3", 32'(pend3), 32'(e_pend[2:0]));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit found, lvl;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset clk_out", 32'(clk_out4), 0);
    chk("reset tick", 32'(tick4), 0);
    chk("reset pending", 32'(pend4), 0);
    for (int k = 1; k <= 10; k++) begin
      idle();
      chk("t1 ch0 clk", 32'(clk_out4[0]), 32'(k >= 5 && k < 10));
      chk("t1 ch0 tick", 32'(tick4[0]), 32'(k == 5));
      chk("t1 ch3 clk", 32'(clk_out4[3]), 32'(k % 2));
      chk("t1 ch3 tick", 32'(tick4[3]), 32'(k % 2));
      chk("t1 pending", 32'(pend4), 0);
    end
    idle();
    step(0, 0, 1, 0, 2);
    chk("t2 pending set", 32'(pend4[0]), 1);
    for (int k = 13; k <= 17; k++) begin
      idle();
      chk("t2 ch0 clk", 32'(clk_out4[0]), 32'(k == 15 || k == 16));
      if (k == 15) chk("t2 pending clear", 32'(pend4[0]), 0);
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_act[1] > 0 && m_rem[1] == 1) found = 1;
      else idle();
    end
    chk("t3 wrap found", 32'(found), 1);
    step(0, 0, 1, 1, 4);
    lvl = clk_out4[1];
    for (int j = 1; j <= 4; j++) begin
      idle();
      chk("t3 ch1 clk", 32'(clk_out4[1]), 32'(j < 4 ? lvl : !lvl));
    end
    step(0, 0, 1, 2, 0);
    repeat (10) idle();
    chk("t4 disabled clk", 32'(clk_out4[2]), 0);
    chk("t4 disabled tick", 32'(tick4[2]), 0);
    step(0, 0, 1, 2, 4);
    idle();
    for (int j = 1; j <= 4; j++) begin
      idle();
      chk("t4 ch2 clk", 32'(clk_out4[2]), 32'(j == 4));
    end
    step(0, 1, 1, 0, 7);
    chk("t5 restart clk", 32'(clk_out4), 0);
    chk("t5 restart tick", 32'(tick4), 0);
    for (int j = 1; j <= 7; j++) begin
      idle();
      chk("t5 ch0 clk", 32'(clk_out4[0]), 32'(j == 7));
      chk("t5 ch0 tick", 32'(tick4[0]), 32'(j == 7));
    end
    step(0, 0, 1, 1, 9);
    step(1, 0, 0, 0, 0);
    chk("t6 reset clk", 32'(clk_out4), 0);
    chk("t6 reset pending", 32'(pend4), 0);
    idle();
    step(0, 0, 1, 3, 6);
    chk("t6 out-of-range pending", 32'(pend3), 0);
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(199) == 0, $urandom_range(39) == 0, $urandom_range(3) == 0,
           int'($urandom_range(3)), int'($urandom_range(6)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
